// File: rtl/lcd_driver.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : lcd_driver                                                    |
// | Purpose  : Write-only HD44780 character LCD driver (8-bit bus). After a  |
// |            power-on wait it sends the init commands 0x38, 0x0C, 0x01 and |
// |            0x06, then accepts single-byte command/data writes. Each      |
// |            write is a SETUP -> ENABLE -> HOLD -> EXEC sequence.          |
// | Ports    : clk_i        - clock, rising edge                             |
// |            rst_i        - synchronous active-high reset                  |
// |            req_valid_i  - write request valid                            |
// |            req_rs_i     - 0 = command, 1 = character data                |
// |            req_data_i   - byte to write                                  |
// |            ready_o      - request accepted when high with req_valid_i    |
// |            init_done_o  - power-on init sequence complete                |
// |            lcd_on_o     - panel power / backlight enable                 |
// |            lcd_en_o     - EN strobe                                      |
// |            lcd_rs_o     - RS                                             |
// |            lcd_rw_o     - RW, tied low                                   |
// |            lcd_data_o   - DB7..DB0                                       |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
module lcd_driver #(
  parameter int unsigned T_PWR   = 750000,
  parameter int unsigned T_SETUP = 2,
  parameter int unsigned T_EN    = 12,
  parameter int unsigned T_HOLD  = 2,
  parameter int unsigned T_EXEC  = 2000,
  parameter int unsigned T_CLEAR = 82000
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       req_valid_i,
  input  logic       req_rs_i,
  input  logic [7:0] req_data_i,
  output logic       ready_o,
  output logic       init_done_o,
  output logic       lcd_on_o,
  output logic       lcd_en_o,
  output logic       lcd_rs_o,
  output logic       lcd_rw_o,
  output logic [7:0] lcd_data_o
);

  // Terminal counts: a state lasting N cycles counts 0 .. N-1.
  localparam logic [19:0] PWR_LAST   = 20'(T_PWR - 1);
  localparam logic [19:0] SETUP_LAST = 20'(T_SETUP - 1);
  localparam logic [19:0] EN_LAST    = 20'(T_EN - 1);
  localparam logic [19:0] HOLD_LAST  = 20'(T_HOLD - 1);
  localparam logic [19:0] EXEC_LAST  = 20'(T_EXEC - 1);
  localparam logic [19:0] CLEAR_LAST = 20'(T_CLEAR - 1);

  typedef enum logic [2:0] {
    PWR_WAIT = 3'd0,
    SETUP    = 3'd1,
    ENABLE   = 3'd2,
    HOLD     = 3'd3,
    EXEC     = 3'd4,
    IDLE     = 3'd5
  } state_t;

  state_t      state_q, state_d;
  logic [19:0] cnt_q, cnt_d;
  logic [1:0]  idx_q, idx_d;        // init command currently being sent
  logic        init_done_q, init_done_d;
  logic        ready_q, ready_d;
  logic        en_q, en_d;
  logic        rs_q, rs_d;
  logic [7:0]  data_q, data_d;
  logic        on_q, on_d;

  logic [19:0] last_w;
  logic        is_clear_w;

  function automatic logic [7:0] init_cmd(input logic [1:0] i);
    case (i)
      2'd0:    init_cmd = 8'h38;  // 8-bit bus, 2 lines, 5x8 font
      2'd1:    init_cmd = 8'h0C;  // display on, cursor off
      2'd2:    init_cmd = 8'h01;  // clear display
      default: init_cmd = 8'h06;  // entry mode: increment, no shift
    endcase
  endfunction

  // Clear (0x01) and return-home (0x02/0x03) need the long execution wait.
  // The decision uses the byte already on the pins, which stays put through
  // EXEC, so the init clear gets the long wait too.
  always_comb begin
    is_clear_w = !rs_q && (data_q == 8'h01 || data_q == 8'h02 || data_q == 8'h03);
    case (state_q)
      PWR_WAIT: last_w = PWR_LAST;
      SETUP:    last_w = SETUP_LAST;
      ENABLE:   last_w = EN_LAST;
      HOLD:     last_w = HOLD_LAST;
      EXEC:     last_w = is_clear_w ? CLEAR_LAST : EXEC_LAST;
      default:  last_w = '0;
    endcase
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    idx_d       = idx_q;
    init_done_d = init_done_q;
    rs_d        = rs_q;
    data_d      = data_q;
    on_d        = 1'b1;

    if (state_q == IDLE) begin
      cnt_d = '0;
      if (req_valid_i && ready_q) begin
        state_d = SETUP;
        rs_d    = req_rs_i;
        data_d  = req_data_i;
      end
    end else if (cnt_q == last_w) begin
      cnt_d = '0;
      case (state_q)
        PWR_WAIT: begin
          state_d = SETUP;
          idx_d   = 2'd0;
          rs_d    = 1'b0;
          data_d  = init_cmd(2'd0);
        end
        SETUP:  state_d = ENABLE;
        ENABLE: state_d = HOLD;
        HOLD:   state_d = EXEC;
        EXEC: begin
          if (init_done_q) begin
            state_d = IDLE;
          end else if (idx_q == 2'd3) begin
            state_d     = IDLE;
            init_done_d = 1'b1;
          end else begin
            state_d = SETUP;
            idx_d   = idx_q + 2'd1;
            rs_d    = 1'b0;
            data_d  = init_cmd(idx_q + 2'd1);
          end
        end
        default: state_d = PWR_WAIT;
      endcase
    end else begin
      cnt_d = cnt_q + 20'd1;
    end

    // Outputs are registered from the next state so they line up exactly
    // with the state they belong to.
    en_d    = (state_d == ENABLE);
    ready_d = (state_d == IDLE);
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= PWR_WAIT;
      cnt_q       <= '0;
      idx_q       <= '0;
      init_done_q <= 1'b0;
      ready_q     <= 1'b0;
      en_q        <= 1'b0;
      rs_q        <= 1'b0;
      data_q      <= '0;
      on_q        <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      idx_q       <= idx_d;
      init_done_q <= init_done_d;
      ready_q     <= ready_d;
      en_q        <= en_d;
      rs_q        <= rs_d;
      data_q      <= data_d;
      on_q        <= on_d;
    end
  end

  assign ready_o     = ready_q;
  assign init_done_o = init_done_q;
  assign lcd_on_o    = on_q;
  assign lcd_en_o    = en_q;
  assign lcd_rs_o    = rs_q;
  assign lcd_rw_o    = 1'b0;
  assign lcd_data_o  = data_q;

endmodule
`default_nettype wire

// File: tb/tb_lcd_driver.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : tb_lcd_driver                                                 |
// | Purpose  : Self-checking bench for lcd_driver. A bus monitor turns every |
// |            EN pulse into a record (rs, data, width, start cycle); the    |
// |            expected pulses and ready timing are derived from the write   |
// |            timing rules with plain arithmetic.                           |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
module tb_lcd_driver;

  localparam int P_PWR   = 10;
  localparam int P_SETUP = 2;
  localparam int P_EN    = 4;
  localparam int P_HOLD  = 2;
  localparam int P_EXEC  = 8;
  localparam int P_CLEAR = 20;
  localparam int WRITE_BASE = P_SETUP + P_EN + P_HOLD;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       req_valid = 1'b0;
  logic       req_rs = 1'b0;
  logic [7:0] req_data = 8'h00;
  logic       ready_o, init_done_o, lcd_on_o, lcd_en_o, lcd_rs_o, lcd_rw_o;
  logic [7:0] lcd_data_o;

  int cyc = 0;
  int n_pass = 0;
  int n_total = 0;

  lcd_driver #(
    .T_PWR  (P_PWR),
    .T_SETUP(P_SETUP),
    .T_EN   (P_EN),
    .T_HOLD (P_HOLD),
    .T_EXEC (P_EXEC),
    .T_CLEAR(P_CLEAR)
  ) dut (
    .clk_i      (clk),
    .rst_i      (rst),
    .req_valid_i(req_valid),
    .req_rs_i   (req_rs),
    .req_data_i (req_data),
    .ready_o    (ready_o),
    .init_done_o(init_done_o),
    .lcd_on_o   (lcd_on_o),
    .lcd_en_o   (lcd_en_o),
    .lcd_rs_o   (lcd_rs_o),
    .lcd_rw_o   (lcd_rw_o),
    .lcd_data_o (lcd_data_o)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- EN pulse monitor ----------------
  typedef struct {
    logic       rs;
    logic [7:0] data;
    int         width;
    int         start;
    bit         stable;
  } pulse_t;

  pulse_t     pq[$];
  logic       en_prev = 1'b0;
  pulse_t     cur;

  always @(negedge clk) begin
    if (lcd_en_o === 1'b1) begin
      if (!en_prev) begin
        cur.rs     = lcd_rs_o;
        cur.data   = lcd_data_o;
        cur.width  = 0;
        cur.start  = cyc;
        cur.stable = 1'b1;
      end
      cur.width = cur.width + 1;
      if (lcd_rs_o !== cur.rs || lcd_data_o !== cur.data) cur.stable = 1'b0;
      en_prev = 1'b1;
    end else begin
      if (en_prev) pq.push_back(cur);
      en_prev = 1'b0;
    end
  end

  // ---------------- helpers ----------------
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed 0x%0h, expected 0x%0h", tag, obs, exp);
  endtask

  function automatic int exec_len(input logic rs, input logic [7:0] d);
    return (!rs && d >= 8'h01 && d <= 8'h03) ? P_CLEAR : P_EXEC;
  endfunction

  task automatic wait_ready(input string tag, input int bound, output int t);
    int n;
    n = 0;
    while (ready_o !== 1'b1 && n < bound) begin
      @(negedge clk);
      n++;
    end
    chk({tag, "_ready_seen"}, 32'(ready_o === 1'b1), 32'd1);
    t = cyc;
  endtask

  task automatic check_pulse(input string tag, input logic rs, input logic [7:0] d,
                             input int start);
    pulse_t p;
    chk({tag, "_pulse_present"}, 32'(pq.size() != 0), 32'd1);
    if (pq.size() != 0) begin
      p = pq.pop_front();
      chk({tag, "_pulse_rs"},     32'(p.rs),     32'(rs));
      chk({tag, "_pulse_data"},   32'(p.data),   32'(d));
      chk({tag, "_pulse_width"},  32'(p.width),  32'(P_EN));
      chk({tag, "_pulse_start"},  32'(p.start),  32'(start));
      chk({tag, "_pulse_stable"}, 32'(p.stable), 32'd1);
    end
  endtask

  // Release reset at the current falling edge and check the full init run.
  task automatic do_init(input string tag);
    logic [7:0] cmds [4];
    int         starts [4];
    int         r0, t, t_exp;
    cmds[0] = 8'h38; cmds[1] = 8'h0C; cmds[2] = 8'h01; cmds[3] = 8'h06;
    pq.delete();
    rst = 1'b0;
    r0  = cyc;
    t_exp = r0 + P_PWR;
    for (int k = 0; k < 4; k++) begin
      starts[k] = t_exp + P_SETUP;
      t_exp += WRITE_BASE + exec_len(1'b0, cmds[k]);
    end
    @(negedge clk);
    chk({tag, "_lcd_on"},        32'(lcd_on_o),    32'd1);
    chk({tag, "_ready_in_pwr"},  32'(ready_o),     32'd0);
    chk({tag, "_rw"},            32'(lcd_rw_o),    32'd0);
    wait_ready(tag, 400, t);
    chk({tag, "_ready_time"},    32'(t - r0),      32'(t_exp - r0));
    chk({tag, "_init_done"},     32'(init_done_o), 32'd1);
    chk({tag, "_npulse"},        32'(pq.size()),   32'd4);
    for (int k = 0; k < 4; k++) check_pulse(tag, 1'b0, cmds[k], starts[k]);
  endtask

  // One write; optionally pulse valid during EXEC, which must be ignored.
  task automatic do_write(input string tag, input logic rs, input logic [7:0] d,
                          input bit ign);
    int t, acc;
    wait_ready(tag, 200, t);
    req_valid = 1'b1;
    req_rs    = rs;
    req_data  = d;
    @(negedge clk);
    acc       = cyc;
    req_valid = 1'b0;
    req_rs    = ~rs;
    req_data  = ~d;
    chk({tag, "_ready_fall"}, 32'(ready_o), 32'd0);
    if (ign) begin
      repeat (WRITE_BASE + 2) @(negedge clk);
      req_valid = 1'b1;
      @(negedge clk);
      req_valid = 1'b0;
      chk({tag, "_ign_data"}, 32'(lcd_data_o), 32'(d));
    end
    wait_ready(tag, 200, t);
    chk({tag, "_latency"},   32'(t - acc),      32'(WRITE_BASE + exec_len(rs, d)));
    chk({tag, "_npulse"},    32'(pq.size()),    32'd1);
    check_pulse(tag, rs, d, acc + P_SETUP);
    chk({tag, "_data_kept"}, 32'(lcd_data_o),   32'(d));
    chk({tag, "_rs_kept"},   32'(lcd_rs_o),     32'(rs));
  endtask

  // ---------------- watchdog ----------------
  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, observed timeout, expected $finish");
    $fatal(1, "watchdog");
  end

  // ---------------- directed / random sequence ----------------
  initial begin
    int t, acc, acc2, n;
    logic       r_rs;
    logic [7:0] r_d;

    // Reset values
    repeat (3) @(negedge clk);
    chk("rst_ready",     32'(ready_o),     32'd0);
    chk("rst_init_done", 32'(init_done_o), 32'd0);
    chk("rst_lcd_on",    32'(lcd_on_o),    32'd0);
    chk("rst_en",        32'(lcd_en_o),    32'd0);
    chk("rst_rs",        32'(lcd_rs_o),    32'd0);
    chk("rst_data",      32'(lcd_data_o),  32'd0);
    chk("rst_rw",        32'(lcd_rw_o),    32'd0);

    do_init("init");

    // Character write and clear command (with a request pulsed during EXEC)
    do_write("wr41",  1'b1, 8'h41, 1'b0);
    do_write("clr01", 1'b0, 8'h01, 1'b1);
    do_write("wr_ign", 1'b1, 8'h55, 1'b1);

    // Back-to-back with valid held high
    wait_ready("b2b", 200, t);
    req_valid = 1'b1;
    req_rs    = 1'b1;
    req_data  = 8'h48;
    @(negedge clk);
    acc      = cyc;
    req_data = 8'h49;
    chk("b2b_first_ready_fall", 32'(ready_o), 32'd0);
    wait_ready("b2b_first", 200, t);
    chk("b2b_first_latency", 32'(t - acc), 32'(WRITE_BASE + P_EXEC));
    @(negedge clk);
    acc2      = cyc;
    req_valid = 1'b0;
    chk("b2b_second_accept", 32'(ready_o), 32'd0);
    wait_ready("b2b_second", 200, t);
    chk("b2b_second_latency", 32'(t - acc2), 32'(WRITE_BASE + P_EXEC));
    chk("b2b_npulse", 32'(pq.size()), 32'd2);
    check_pulse("b2b_first",  1'b1, 8'h48, acc + P_SETUP);
    check_pulse("b2b_second", 1'b1, 8'h49, acc2 + P_SETUP);

    // Randomized writes, biased to hit clear/home commands
    for (int i = 0; i < 8; i++) begin
      r_rs = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 2) == 0) r_d = 8'($urandom_range(1, 3));
      else                           r_d = 8'($urandom);
      do_write($sformatf("rnd%0d", i), r_rs, r_d, 1'($urandom_range(0, 1)));
    end

    // Reset in the middle of ENABLE
    wait_ready("mid", 200, t);
    req_valid = 1'b1;
    req_rs    = 1'b1;
    req_data  = 8'h5A;
    @(negedge clk);
    req_valid = 1'b0;
    n = 0;
    while (lcd_en_o !== 1'b1 && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk("mid_en_seen", 32'(lcd_en_o), 32'd1);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("mid_rst_en",        32'(lcd_en_o),    32'd0);
    chk("mid_rst_init_done", 32'(init_done_o), 32'd0);
    chk("mid_rst_ready",     32'(ready_o),     32'd0);
    chk("mid_rst_lcd_on",    32'(lcd_on_o),    32'd0);
    chk("mid_rst_data",      32'(lcd_data_o),  32'd0);
    @(negedge clk);
    do_init("reinit");
    do_write("post_reinit", 1'b1, 8'h7E, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/lcd_driver.md
LCD_DRIVER -- requirements
Module: lcd_driver

Interface
REQ-001 The block SHALL have these parameters (name, default, meaning):
- T_PWR, 750000: power-on wait, cycles.
- T_SETUP, 2: RS/data setup before EN rise, cycles.
- T_EN, 12: EN high width, cycles.
- T_HOLD, 2: RS/data hold after EN fall, cycles.
- T_EXEC, 2000: post-write execution wait, cycles.
- T_CLEAR, 82000: execution wait for clear/home commands, cycles.
REQ-002 All parameters SHALL be at least 1 and at most 2^20-1; the internal wait counter SHALL be 20 bits.
REQ-003 The block SHALL have these ports (name, direction, width, meaning):
- clk_i, in, 1: single clock; all logic on its rising edge.
- rst_i, in, 1: reset; synchronous, active-high.
- req_valid_i, in, 1: write request valid.
- req_rs_i, in, 1: 0 = command, 1 = character data.
- req_data_i, in, 8: byte to write.
- ready_o, out, 1: block can accept a request.
- init_done_o, out, 1: power-on init sequence complete.
- lcd_on_o, out, 1: panel power/backlight enable.
- lcd_en_o, out, 1: HD44780 EN strobe.
- lcd_rs_o, out, 1: HD44780 RS.
- lcd_rw_o, out, 1: HD44780 RW; always 0 (write-only).
- lcd_data_o, out, 8: HD44780 DB7..DB0.

Function
REQ-004 The FSM SHALL have states PWR_WAIT, SETUP, ENABLE, HOLD, EXEC, IDLE.
REQ-005 After reset, the FSM SHALL stay in PWR_WAIT for exactly T_PWR cycles.
REQ-006 It SHALL then issue init commands 0x38, 0x0C, 0x01, 0x06 (RS=0), in order, each through SETUP->ENABLE->HOLD->EXEC.
REQ-007 After the fourth init EXEC, init_done_o SHALL go 1 and the FSM SHALL enter IDLE; init_done_o SHALL stay 1 until reset.
REQ-008 ready_o SHALL be 1 only in IDLE; it is a registered output.
REQ-009 A request SHALL be accepted on a cycle where req_valid_i=1 and ready_o=1.
- req_rs_i and req_data_i are captured on that edge.
- ready_o SHALL be 0 starting the next cycle.
REQ-010 req_valid_i SHALL be ignored while ready_o=0; there is no queuing.
REQ-011 SETUP SHALL last T_SETUP cycles with lcd_en_o=0 and the captured RS/data on the pins.
REQ-012 ENABLE SHALL last T_EN cycles with lcd_en_o=1.
REQ-013 HOLD SHALL last T_HOLD cycles with lcd_en_o=0.
REQ-014 lcd_rs_o and lcd_data_o SHALL be stable from the first SETUP cycle through the last HOLD cycle, and SHALL retain their last value afterwards.
REQ-015 EXEC SHALL last T_CLEAR cycles when RS=0 and data is 0x01, 0x02 or 0x03; otherwise it SHALL last T_EXEC cycles.
REQ-016 Total latency from the accept edge to ready_o=1 SHALL be T_SETUP+T_EN+T_HOLD+T_EXEC cycles (T_CLEAR instead of T_EXEC for clear/home).
REQ-017 Exactly one EN pulse SHALL be produced per accepted request, and one per init command.
REQ-018 Back-to-back: a request held valid at the IDLE re-entry cycle SHALL be accepted on that cycle.
REQ-019 lcd_rw_o SHALL be constant 0.
REQ-020 lcd_on_o SHALL be 1 from the first cycle after reset deasserts.

Reset
REQ-021 When rst_i=1 at a clock edge, the block SHALL set:
- ready_o=0, init_done_o=0, lcd_on_o=0
- lcd_en_o=0, lcd_rs_o=0, lcd_data_o=0x00
- FSM=PWR_WAIT, counter=0
REQ-022 Reset asserted mid-operation (including during ENABLE) SHALL force lcd_en_o=0 on the next edge, abandon the write, and restart the full init sequence once released.

Verification
REQ-023 The bench SHALL run with T_PWR=10, T_SETUP=2, T_EN=4, T_HOLD=2, T_EXEC=8, T_CLEAR=20 and cover these scenarios:
- Init: release reset -> 10 idle cycles, then EN pulses with data 0x38, 0x0C, 0x01, 0x06 (RS=0, each EN high 4 cycles), then init_done_o=1 and ready_o=1.
- Data write: after init, valid with rs=1, data=0x41 -> ready_o falls next cycle; EN high 4 cycles after 2 setup cycles; ready_o returns 16 cycles after accept.
- Clear command: rs=0, data=0x01 -> ready_o returns 28 cycles after accept.
- Back-to-back: valid held continuously with 0x48 then 0x49 -> two EN pulses, with the second accepted on the ready_o re-assert cycle.
- Ignored request: pulse valid during EXEC -> no extra EN pulse and no change to lcd_data_o.
- Mid-write reset: assert rst_i during ENABLE -> lcd_en_o=0 and init_done_o=0 next cycle; init restarts with the 10-cycle wait.
